// File: rtl/rled_effects.sv
// Display-effect stage between the red-LED PIO out_port and the LEDR pins.
// It applies pass-through, PWM dim, blink or a pattern-masked single-LED chase.
module rled_effects #(
  parameter int WIDTH       = 18,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_in,
  input  logic [1:0]       mode,
  input  logic [3:0]       duty,
  output logic [WIDTH-1:0] led_out,
  output logic             tick
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int BC_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_TICKS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_DIM   = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_CHASE = 2'b11
  } mode_t;

  logic [WIDTH-1:0] led_q;
  mode_t            mode_q;
  logic [3:0]       duty_q;
  logic [PS_W-1:0]  prescaler;
  logic [3:0]       pwm_cnt;
  logic [BC_W-1:0]  blink_cnt;
  logic             blink_phase;
  logic [POS_W-1:0] pos;
  logic             mode_chg;
  logic             pwm_on;

  assign mode_chg = (mode_t'(mode) != mode_q);
  assign pwm_on   = (duty_q == 4'hF) | (pwm_cnt < duty_q);

  function automatic logic [WIDTH-1:0] effect_mask(input mode_t            m,
                                                   input logic             pwm_on_i,
                                                   input logic             phase_i,
                                                   input logic [POS_W-1:0] pos_i);
    logic [WIDTH-1:0] one_hot;
    one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << pos_i;
    case (m)
      MODE_DIM:   return {WIDTH{pwm_on_i}};
      MODE_BLINK: return {WIDTH{phase_i}};
      MODE_CHASE: return one_hot;
      default:    return '1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    // input stage: duty is pure data and is left out of reset
    duty_q <= duty;
    if (reset) begin
      led_q       <= '0;
      mode_q      <= MODE_PASS;
      led_out     <= '0;
      tick        <= 1'b0;
      prescaler   <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      pos         <= '0;
    end else begin
      led_q   <= led_in;
      mode_q  <= mode_t'(mode);
      prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      tick      <= (prescaler == PS_LAST);
      pwm_cnt   <= pwm_cnt + 4'd1;
      // output stage
      led_out <= led_q & effect_mask(mode_q, pwm_on, blink_phase, pos);
      // a mode change restarts the effect timers and overrides a coincident tick
      if (mode_chg) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
        pos         <= '0;
      end else if (tick) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
        pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rled_effects.sv
// Directed bench for rled_effects with a short prescaler and blink period.
module tb_rled_effects;

  logic        clk;
  logic        reset;
  logic [17:0] led_in;
  logic [1:0]  mode;
  logic [3:0]  duty;
  logic [17:0] led_out;
  logic        tick;

  int checks;
  int failures;
  int cyc;

  rled_effects #(
    .WIDTH(18),
    .PRESCALE(4),
    .BLINK_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .led_in(led_in),
    .mode(mode),
    .duty(duty),
    .led_out(led_out),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release, used to line stimulus up with ticks
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sample16(input logic [17:0] v, output int n_v, output int n_other);
    n_v = 0;
    n_other = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led_out == v) n_v++;
      else if (led_out != 18'h0) n_other++;
    end
  endtask

  task automatic run_len(input logic [17:0] v, output int n);
    n = 0;
    while (led_out === v && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n_on, n_bad, len;
    logic [17:0] pat, exp_v;
    string tag;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    led_in = 18'h0;
    mode = 2'b00;
    duty = 4'd0;

    // reset and pass-through
    repeat (3) @(negedge clk);
    check_val("reset_led", led_out, 0);
    check_val("reset_tick", tick, 0);
    reset = 1'b0;
    led_in = 18'h2A5A5;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_val("pass_tick", tick, (k % 4 == 0) ? 1 : 0);
      check_val("pass_led", led_out, (k == 1) ? 0 : 18'h2A5A5);
    end

    // PWM dimming
    led_in = 18'h3FFFF;
    mode = 2'b01;
    duty = 4'd4;
    repeat (3) @(negedge clk);
    sample16(18'h3FFFF, n_on, n_bad);
    check_val("dim4_on", n_on, 4);
    check_val("dim4_bad", n_bad, 0);
    duty = 4'd0;
    repeat (3) @(negedge clk);
    sample16(18'h3FFFF, n_on, n_bad);
    check_val("dim0_on", n_on, 0);
    check_val("dim0_bad", n_bad, 0);
    duty = 4'd15;
    repeat (3) @(negedge clk);
    sample16(18'h3FFFF, n_on, n_bad);
    check_val("dim15_on", n_on, 16);

    // blink
    mode = 2'b10;
    led_in = 18'h00F0F;
    repeat (2) @(negedge clk);
    check_val("blink_first_on", led_out, 18'h00F0F);
    for (int i = 0; i < 30 && led_out != 18'h0; i++) @(negedge clk);
    check_val("blink_reach_off", led_out, 0);
    run_len(18'h0, len);
    check_val("blink_off_len", len, 12);
    check_val("blink_back_on", led_out, 18'h00F0F);
    run_len(18'h00F0F, len);
    check_val("blink_on_len", len, 12);
    check_val("blink_off_again", led_out, 0);
    mode = 2'b00;
    repeat (2) @(negedge clk);
    check_val("pass_mid", led_out, 18'h00F0F);
    @(negedge clk);
    mode = 2'b10;
    repeat (2) @(negedge clk);
    check_val("blink_restart", led_out, 18'h00F0F);
    run_len(18'h00F0F, len);
    check_val("blink_restart_len", (len >= 9 && len <= 12) ? 1 : 0, 1);

    // chase, entered in the same cycle a tick is consumed
    for (int i = 0; i < 8 && (cyc % 4) != 0; i++) @(negedge clk);
    check_val("tick_align", tick, 1);
    mode = 2'b11;
    led_in = 18'h3FFFF;
    @(negedge clk);
    for (int s = 0; s <= 172; s++) begin
      @(negedge clk);
      pat = (s >= 82 && s < 157) ? 18'h00005 : 18'h3FFFF;
      exp_v = pat & (18'h1 << ((s / 4) % 18));
      if (s < 4) tag = "chase_collision";
      else tag = "chase_step";
      check_val(tag, led_out, exp_v);
      if (s == 80) led_in = 18'h00005;
      if (s == 155) led_in = 18'h3FFFF;
    end

    // reset while the chase sits at bit 7
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_mid_led", led_out, 0);
    check_val("reset_mid_tick", tick, 0);
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_v = (k == 1) ? 18'h0 : (18'h1 << ((k - 2) / 4));
      check_val("chase_resume", led_out, exp_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rled_effects.md
Name: rled_effects

Overview:
- Downstream consumer of the red-LED PIO's 18-bit `out_port`; sits between that PIO and the board LEDR pins.
- Applies a selectable display effect to the software-written LED pattern: pass-through, PWM dimming, blinking, or a single-LED chase masked by the pattern.
- Mode and duty come from a separate control PIO; all timing comes from an internal prescaler.

Parameters:
- WIDTH, 18, LED count; equals the PIO out_port width.
- PRESCALE, 50000, clk cycles per effect tick (1 kHz at 50 MHz); legal range >= 2.
- BLINK_TICKS, 250, ticks per blink half-period; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- led_in  input  WIDTH  pattern from the LED PIO out_port.
- mode  input  2  00 pass, 01 dim, 10 blink, 11 chase.
- duty  input  4  PWM on-count out of 16; 15 = fully on.
- led_out  output  WIDTH  registered LED drive.
- tick  output  1  one-cycle pulse per prescaler wrap.

Behaviour:
- One clock domain, clk only. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - led_out=0, tick=0, led_q=0, mode_q=00.
  - prescaler, pwm_cnt, blink_cnt and pos all =0.
  - blink_phase=1 (on).
- Input stage: led_in, mode and duty are registered every cycle into led_q, mode_q and duty_q.
- Output stage: led_out is registered from led_q and the effect logic.
- Latency: led_in to led_out is 2 cycles in pass mode. Mode change to new effect visible on led_out is 2 cycles.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick=1 in the cycle after prescaler==PRESCALE-1, i.e. registered.
  - Free-running; unaffected by mode.
- PWM:
  - pwm_cnt is 4 bits, increments every clk, wraps 15->0; period is 16 cycles.
  - pwm_on = (duty_q==15) | (pwm_cnt < duty_q).
  - duty_q=0 gives always off.
- Blink:
  - On each tick, blink_cnt increments.
  - At BLINK_TICKS-1 with a tick, blink_cnt returns to 0 and blink_phase toggles.
- Chase:
  - On each tick, pos increments; WIDTH-1 wraps to 0.
- Effect mux (state = mode_q):
  - PASS: led_out <= led_q.
  - DIM: led_out <= led_q & {WIDTH{pwm_on}}.
  - BLINK: led_out <= led_q & {WIDTH{blink_phase}}.
  - CHASE: led_out <= led_q & (1<<pos). A zero pattern gives an all-zero output; pos still advances.
- Mode transition:
  - Detected when mode differs from mode_q.
  - In that cycle: blink_cnt=0, blink_phase=1, pos=0.
  - Prescaler and pwm_cnt are not disturbed.
  - The new state takes effect on the next cycle.
- Simultaneous tick and mode change: the mode-change clear wins; no increment is applied that cycle.
- led_in changing mid-effect: the new pattern takes effect immediately (2-cycle latency). Timers are not restarted.
- Reset asserted mid-operation: all state returns to reset values on the next edge. First tick occurs PRESCALE cycles after reset deasserts.
- Widths: all counters are unsigned.
  - prescaler is $clog2(PRESCALE) bits.
  - blink_cnt is $clog2(BLINK_TICKS) bits, minimum 1.
  - pos is $clog2(WIDTH) bits.
  - No overflow is possible beyond the defined wraps.

Test Plan:
- Reset and pass (PRESCALE=4, BLINK_TICKS=3):
  - Hold reset 3 cycles -> led_out=0, tick=0.
  - Release, mode=00, led_in=18'h2A5A5 -> led_out=18'h2A5A5 exactly 2 cycles later.
  - tick pulses every 4 cycles, first 4 cycles after reset release.
- Dim (led_in=18'h3FFFF, mode=01):
  - duty=4 -> led_out all-ones for 4 of every 16 cycles.
  - duty=0 -> constant 0.
  - duty=15 -> constant 18'h3FFFF.
- Blink (mode=10, led_in=18'h00F0F):
  - led_out=18'h00F0F for 3 ticks (12 cycles), then 0 for 12 cycles, repeating.
  - A mode change to 00 then back to 10 restarts with the on phase.
- Chase (mode=11, led_in=18'h3FFFF):
  - led_out walks 18'h00001, 00002, ... 20000, then back to 00001, one step per tick.
  - With led_in=18'h00005, output is non-zero only at pos 0 and 2.
- Collision and mid-run reset:
  - Change mode in the same cycle a tick is generated -> pos/blink_cnt cleared, not incremented.
  - Assert reset during chase at pos=7 -> led_out=0 and pos=0 next cycle; chase resumes from bit 0 after release.
